// File: rtl/binning_pkg.sv
// binning_pkg: shared types and factor decoding for the NxN pixel binning pipeline.
package binning_pkg;
    localparam int ACC_EXTRA_BITS = 4;

    typedef enum logic [1:0] {
        FACTOR_1X1     = 2'd0,
        FACTOR_2X2     = 2'd1,
        FACTOR_4X4     = 2'd2,
        FACTOR_4X4_ALT = 2'd3
    } factor_e;

    typedef enum logic {
        MODE_AVG = 1'b0,
        MODE_SUM = 1'b1
    } mode_e;

    typedef struct packed {
        logic [2:0] k;
        logic [2:0] sh;
    } kinfo_t;

    // sh is log2(K*K): the averaging shift, and twice the column shift
    function automatic kinfo_t factor_info(factor_e f);
        return f == FACTOR_1X1 ? kinfo_t'{k: 3'd1, sh: 3'd0} :
               f == FACTOR_2X2 ? kinfo_t'{k: 3'd2, sh: 3'd2} :
                                 kinfo_t'{k: 3'd4, sh: 3'd4};
    endfunction
endpackage

// File: rtl/binning_line_ram.sv
// binning_line_ram: simple dual-port line buffer with registered read and
// write-to-read forwarding when both ports hit the same address.
module binning_line_ram #(
    parameter int DEPTH = 2048,
    parameter int WIDTH = 12,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= (we_i && waddr_i == raddr_i) ? wdata_i : mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/binning_nxn.sv
// binning_nxn: KxK pixel binning (average or saturating sum) over a video stream,
// two-cycle latency: stage 1 accumulates the vertical sum, stage 2 registers the result.
module binning_nxn
    import binning_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int CHANNELS      = 1,
    parameter int LINE_SIZE_MAX = 4096
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           bypass,
    input  logic [1:0]                     factor,
    input  logic                           mode,
    input  logic [DATA_WIDTH*CHANNELS-1:0] di_i,
    input  logic                           de_i,
    input  logic                           hs_i,
    input  logic                           vs_i,
    output logic [DATA_WIDTH*CHANNELS-1:0] do_o,
    output logic                           de_o,
    output logic                           hs_o,
    output logic                           vs_o
);
    localparam int SW    = DATA_WIDTH + ACC_EXTRA_BITS;
    localparam int W     = SW * CHANNELS;
    localparam int DEPTH = LINE_SIZE_MAX / 2;
    localparam int AW    = $clog2(DEPTH);
    localparam int XW    = $clog2(LINE_SIZE_MAX) + 1;
    localparam logic [XW-1:0] X_LIM = XW'(LINE_SIZE_MAX);

    logic vs_p_q, hs_p_q, run_q, seen_q, byp_q;
    factor_e factor_q;
    mode_e mode_q;
    logic [XW-1:0] x_q;
    logic [1:0] y_q;
    logic [W-1:0] hacc_q, hsum_d, s1_sum_q, vsum_d, rd_data;
    logic s1_v_q, s1_first_q, s1_last_q;
    logic [AW-1:0] s1_col_q, col_d;
    logic [DATA_WIDTH*CHANNELS-1:0] b1_d_q, bin_d, do_q;
    logic b1_v_q, hs1_q, vs1_q, de_q, hs_q, vs_q;
    kinfo_t ki;
    logic [1:0] kmask, xm, ym;
    logic vs_rise, hs_rise, take, first_x, last_x, first_y, last_y;
    logic [SW-1:0] rnd;

    assign ki      = factor_info(factor_q);
    assign kmask   = 2'(ki.k - 3'd1);
    assign xm      = x_q[1:0] & kmask;
    assign ym      = y_q & kmask;
    assign first_x = xm == 2'd0;
    assign last_x  = xm == kmask;
    assign first_y = ym == 2'd0;
    assign last_y  = ym == kmask;
    assign vs_rise = vs_i & ~vs_p_q;
    assign hs_rise = hs_i & ~hs_p_q;
    assign take    = de_i & vs_i & run_q & ~byp_q & (x_q < X_LIM);
    assign col_d   = AW'(x_q >> ki.sh[2:1]);
    assign rnd     = (SW'(1) << ki.sh) >> 1;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [SW-1:0] v;
        logic [DATA_WIDTH-1:0] avg;
        assign hsum_d[c*SW +: SW] = (first_x ? '0 : hacc_q[c*SW +: SW]) + SW'(di_i[c*DATA_WIDTH +: DATA_WIDTH]);
        assign v = s1_sum_q[c*SW +: SW] + (s1_first_q ? '0 : rd_data[c*SW +: SW]);
        assign vsum_d[c*SW +: SW] = v;
        assign avg = DATA_WIDTH'((v + rnd) >> ki.sh);
        assign bin_d[c*DATA_WIDTH +: DATA_WIDTH] = mode_q == MODE_SUM ?
            (v > SW'({DATA_WIDTH{1'b1}}) ? '1 : v[DATA_WIDTH-1:0]) : avg;
    end

    // Rows with y%K==0 overwrite, so RAM contents never need a reset
    binning_line_ram #(.DEPTH(DEPTH), .WIDTH(W), .AW(AW)) u_ram (
        .clk    (clk),
        .we_i   (s1_v_q & ~s1_last_q),
        .waddr_i(s1_col_q),
        .wdata_i(vsum_d),
        .re_i   (take & last_x & ~first_y),
        .raddr_i(col_d),
        .rdata_o(rd_data)
    );

    // Edge detectors reset high so a frame already running at release is ignored
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vs_p_q     <= 1'b1;
            hs_p_q     <= 1'b1;
            run_q      <= 1'b0;
            seen_q     <= 1'b0;
            byp_q      <= 1'b0;
            factor_q   <= FACTOR_1X1;
            mode_q     <= MODE_AVG;
            x_q        <= '0;
            y_q        <= '0;
            hacc_q     <= '0;
            s1_v_q     <= 1'b0;
            s1_sum_q   <= '0;
            s1_col_q   <= '0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            b1_d_q     <= '0;
            b1_v_q     <= 1'b0;
            hs1_q      <= 1'b1;
            vs1_q      <= 1'b0;
            do_q       <= '0;
            de_q       <= 1'b0;
            hs_q       <= 1'b1;
            vs_q       <= 1'b0;
        end else begin
            vs_p_q <= vs_i;
            hs_p_q <= hs_i;
            if (vs_rise) begin
                byp_q    <= bypass;
                factor_q <= factor_e'(factor);
                mode_q   <= mode_e'(mode);
                run_q    <= 1'b1;
                x_q      <= '0;
                y_q      <= '0;
                seen_q   <= 1'b0;
            end else if (hs_rise) begin
                x_q    <= '0;
                seen_q <= 1'b0;
                if (seen_q) y_q <= y_q + 2'd1;
            end else if (de_i) begin
                seen_q <= 1'b1;
                if (x_q < X_LIM) x_q <= x_q + 1'b1;
            end
            if (take) hacc_q <= hsum_d;
            s1_v_q     <= take & last_x;
            s1_sum_q   <= hsum_d;
            s1_col_q   <= col_d;
            s1_first_q <= first_y;
            s1_last_q  <= last_y;
            b1_d_q     <= di_i;
            b1_v_q     <= de_i;
            hs1_q      <= hs_i;
            vs1_q      <= vs_i;
            do_q       <= byp_q ? b1_d_q : bin_d;
            de_q       <= byp_q ? b1_v_q : s1_v_q & s1_last_q;
            hs_q       <= hs1_q;
            vs_q       <= vs1_q;
        end
    end

    assign do_o = do_q;
    assign de_o = de_q;
    assign hs_o = hs_q;
    assign vs_o = vs_q;
endmodule
